// File: rtl/cellrv32_package.sv
// Shared definitions for the cellrv32 CPU: FPU operation encodings, exception
// flag bit positions and the FPU sequencer state type.
package cellrv32_package;

    localparam logic [2:0] fp_op_f2i_c    = 3'd0;
    localparam logic [2:0] fp_op_i2f_c    = 3'd1;
    localparam logic [2:0] fp_op_addsub_c = 3'd2;
    localparam logic [2:0] fp_op_mul_c    = 3'd3;
    localparam logic [2:0] fp_op_direct_c = 3'd4;

    // Bit positions inside the 5-bit fflags vector.
    localparam int fp_exc_nv_c = 4;
    localparam int fp_exc_dz_c = 3;
    localparam int fp_exc_of_c = 2;
    localparam int fp_exc_uf_c = 1;
    localparam int fp_exc_nx_c = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT,
        S_DONE
    } fpu_seq_state_t;

    // Rounding modes 5 and 6 are reserved; 7 is only meaningful before resolution.
    function automatic logic fp_rm_illegal(input logic [2:0] rm);
        return (rm == 3'd5) || (rm == 3'd6) || (rm == 3'd7);
    endfunction

endpackage

// File: rtl/cellrv32_cpu_cp_fpu32_seq.sv
// Single-precision FPU operation sequencer: dispatches one operation to a
// multi-cycle unit or takes the direct result, then completes and merges fflags.
module cellrv32_cpu_cp_fpu32_seq
    import cellrv32_package::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [2:0]       rm_i,
    input  logic [2:0]       frm_i,
    input  logic             abort_i,
    output logic [3:0]       unit_start_o,
    output logic [2:0]       rmode_o,
    input  logic [3:0]       unit_done_i,
    input  logic [3:0][31:0] unit_res_i,
    input  logic [3:0][4:0]  unit_flags_i,
    input  logic [31:0]      direct_res_i,
    input  logic [4:0]       direct_flags_i,
    input  logic             fflags_we_i,
    input  logic [4:0]       fflags_wdata_i,
    output logic [4:0]       fflags_o,
    output logic [31:0]      result_o,
    output logic             valid_o,
    output logic             illegal_o,
    output logic             timeout_o,
    output logic             busy_o
);

    localparam int             CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fpu_seq_state_t   state;
    logic [2:0]       op_q;
    logic             illegal_q;
    logic [31:0]      cap_res;
    logic [4:0]       cap_flags;
    logic [CNT_W-1:0] cnt;

    logic [2:0] rm_res;
    logic       req_illegal;
    logic       req_direct;
    logic       merge;

    assign rm_res      = (rm_i == 3'b111) ? frm_i : rm_i;
    assign req_illegal = (op_i > fp_op_direct_c) || fp_rm_illegal(rm_res);
    assign req_direct  = (op_i == fp_op_direct_c);
    assign busy_o      = (state != S_IDLE);
    assign merge       = (state == S_DONE) && !abort_i && !illegal_o && !timeout_o;

    // Direct and illegal requests also pass through S_DISPATCH (without a start
    // pulse), so every completion is produced by the same registered path.
    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= S_IDLE;
            op_q         <= '0;
            illegal_q    <= 1'b0;
            cap_res      <= '0;
            cap_flags    <= '0;
            cnt          <= '0;
            unit_start_o <= '0;
            rmode_o      <= '0;
            result_o     <= '0;
            valid_o      <= 1'b0;
            illegal_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else if (abort_i && (state != S_IDLE)) begin
            state        <= S_IDLE;
            unit_start_o <= '0;
            valid_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    valid_o <= 1'b0;
                    if (start_i) begin
                        op_q      <= op_i;
                        rmode_o   <= rm_res;
                        illegal_q <= req_illegal;
                        cap_res   <= (req_direct && !req_illegal) ? direct_res_i : '0;
                        cap_flags <= (req_direct && !req_illegal) ? direct_flags_i : '0;
                        if (!req_illegal && !req_direct)
                            unit_start_o <= 4'b0001 << op_i[1:0];
                        state <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    unit_start_o <= '0;
                    cnt          <= '0;
                    if (illegal_q || (op_q == fp_op_direct_c)) begin
                        result_o  <= cap_res;
                        illegal_o <= illegal_q;
                        timeout_o <= 1'b0;
                        valid_o   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (unit_done_i[op_q[1:0]]) begin
                        result_o  <= unit_res_i[op_q[1:0]];
                        cap_flags <= unit_flags_i[op_q[1:0]];
                        illegal_o <= 1'b0;
                        timeout_o <= 1'b0;
                        valid_o   <= 1'b1;
                        state     <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        result_o  <= '0;
                        cap_flags <= '0;
                        illegal_o <= 1'b0;
                        timeout_o <= 1'b1;
                        valid_o   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    valid_o <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A CSR write replaces the old accrued value but never drops flags merged
    // by a completion in the same cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            fflags_o <= '0;
        else if (fflags_we_i || merge)
            fflags_o <= (fflags_we_i ? fflags_wdata_i : fflags_o) | (merge ? cap_flags : 5'b0);
    end

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu32_seq.sv
// Directed bench for the FPU sequencer: latency, illegal, timeout, abort,
// fflags CSR interaction and asynchronous reset.
module tb_cellrv32_cpu_cp_fpu32_seq;
    import cellrv32_package::*;

    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = '0;
    logic [2:0]       rm = '0;
    logic [2:0]       frm = '0;
    logic             abort = 1'b0;
    logic [3:0]       unit_start;
    logic [2:0]       rmode;
    logic [3:0]       unit_done = '0;
    logic [3:0][31:0] unit_res = '0;
    logic [3:0][4:0]  unit_flags = '0;
    logic [31:0]      direct_res = '0;
    logic [4:0]       direct_flags = '0;
    logic             fflags_we = 1'b0;
    logic [4:0]       fflags_wdata = '0;
    logic [4:0]       fflags;
    logic [31:0]      result;
    logic             valid;
    logic             illegal;
    logic             timeout;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cellrv32_cpu_cp_fpu32_seq #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .op_i(op), .rm_i(rm), .frm_i(frm),
        .abort_i(abort), .unit_start_o(unit_start), .rmode_o(rmode),
        .unit_done_i(unit_done), .unit_res_i(unit_res), .unit_flags_i(unit_flags),
        .direct_res_i(direct_res), .direct_flags_i(direct_flags),
        .fflags_we_i(fflags_we), .fflags_wdata_i(fflags_wdata), .fflags_o(fflags),
        .result_o(result), .valid_o(valid), .illegal_o(illegal), .timeout_o(timeout),
        .busy_o(busy)
    );

    task automatic test_reset;
        #3;
        vectors++; if ({unit_start, rmode, fflags, result} !== '0) begin miscompares++;
            $display("FAIL reset_data: start=%b rmode=%b fflags=%b result=%h want all 0", unit_start, rmode, fflags, result); end
        vectors++; if ({valid, illegal, timeout, busy} !== 4'b0) begin miscompares++;
            $display("FAIL reset_ctrl: valid/illegal/timeout/busy=%b want 0000", {valid, illegal, timeout, busy}); end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_f2i_dynamic_rm;
        start = 1'b1; op = fp_op_f2i_c; rm = 3'b111; frm = 3'b001;
        @(negedge clk); start = 1'b0; rm = 3'b000; frm = 3'b000;
        vectors++; if (unit_start !== 4'b0001) begin miscompares++; $display("FAIL f2i_start: got %b want 0001", unit_start); end
        vectors++; if (rmode !== 3'b001) begin miscompares++; $display("FAIL f2i_rmode: got %b want 001", rmode); end
        @(negedge clk);
        vectors++; if (unit_start !== 4'b0000) begin miscompares++; $display("FAIL f2i_start_pulse: got %b want 0000", unit_start); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL f2i_early_valid: cycle %0d got %b want 0", i + 2, valid); end
            @(negedge clk);
        end
        unit_done[0] = 1'b1; unit_res[0] = 32'h7fffffff; unit_flags[0] = 5'b10000;
        @(negedge clk); unit_done = '0; unit_res = '0; unit_flags = '0;
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL f2i_valid: got %b want 1", valid); end
        vectors++; if (result !== 32'h7fffffff) begin miscompares++; $display("FAIL f2i_result: got %h want 7fffffff", result); end
        vectors++; if ({illegal, timeout} !== 2'b00) begin miscompares++; $display("FAIL f2i_qual: got %b want 00", {illegal, timeout}); end
        vectors++; if (rmode !== 3'b001) begin miscompares++; $display("FAIL f2i_rmode_hold: got %b want 001", rmode); end
        vectors++; if (fflags !== 5'b00000) begin miscompares++; $display("FAIL f2i_fflags_early: got %b want 00000", fflags); end
        @(negedge clk);
        vectors++; if (fflags !== 5'(1 << fp_exc_nv_c)) begin miscompares++; $display("FAIL f2i_fflags_nv: got %b want 10000", fflags); end
        vectors++; if ({valid, busy} !== 2'b00) begin miscompares++; $display("FAIL f2i_idle: valid/busy=%b want 00", {valid, busy}); end
    endtask

    task automatic test_illegal(input logic [2:0] op_v, input logic [2:0] rm_v, input logic [4:0] ff_exp);
        start = 1'b1; op = op_v; rm = rm_v; direct_flags = 5'b11111; direct_res = 32'hffffffff;
        @(negedge clk); start = 1'b0;
        vectors++; if ({unit_start, valid} !== 5'b0) begin miscompares++; $display("FAIL ill_t1 op%0d rm%0d: start=%b valid=%b want 0", op_v, rm_v, unit_start, valid); end
        @(negedge clk);
        vectors++; if ({valid, illegal, timeout} !== 3'b110) begin miscompares++; $display("FAIL ill_valid op%0d rm%0d: v/i/t=%b want 110", op_v, rm_v, {valid, illegal, timeout}); end
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL ill_result op%0d rm%0d: got %h want 0", op_v, rm_v, result); end
        vectors++; if (unit_start !== 4'b0) begin miscompares++; $display("FAIL ill_nostart op%0d rm%0d: got %b want 0000", op_v, rm_v, unit_start); end
        @(negedge clk); direct_flags = '0; direct_res = '0;
        vectors++; if (fflags !== ff_exp) begin miscompares++; $display("FAIL ill_fflags op%0d rm%0d: got %b want %b", op_v, rm_v, fflags, ff_exp); end
        vectors++; if ({valid, busy} !== 2'b00) begin miscompares++; $display("FAIL ill_idle op%0d: valid/busy=%b want 00", op_v, {valid, busy}); end
    endtask

    task automatic test_back_to_back;
        start = 1'b1; op = fp_op_direct_c; rm = 3'b000; direct_res = 32'h3f800000; direct_flags = 5'b00010;
        @(negedge clk); start = 1'b0; direct_res = '0; direct_flags = '0;
        @(negedge clk);
        vectors++; if ({valid, illegal} !== 2'b10 || result !== 32'h3f800000) begin miscompares++;
            $display("FAIL b2b_first: valid/illegal=%b result=%h want 10 3f800000", {valid, illegal}, result); end
        @(negedge clk);
        start = 1'b1; direct_res = 32'hc0490fdb; direct_flags = 5'b01000;
        vectors++; if (fflags !== 5'b10010) begin miscompares++; $display("FAIL b2b_merge1: got %b want 10010", fflags); end
        @(negedge clk); start = 1'b0; direct_res = '0; direct_flags = '0;
        @(negedge clk);
        vectors++; if (valid !== 1'b1 || result !== 32'hc0490fdb) begin miscompares++;
            $display("FAIL b2b_second: valid=%b result=%h want 1 c0490fdb", valid, result); end
        @(negedge clk);
        vectors++; if (fflags !== 5'b11010) begin miscompares++; $display("FAIL b2b_merge2: got %b want 11010", fflags); end
    endtask

    task automatic test_timeout;
        start = 1'b1; op = fp_op_mul_c; rm = 3'b010; unit_res[3] = 32'h12345678; unit_flags[3] = 5'b00001;
        @(negedge clk); start = 1'b0;
        vectors++; if (unit_start !== 4'b1000 || rmode !== 3'b010) begin miscompares++;
            $display("FAIL to_start: start=%b rmode=%b want 1000 010", unit_start, rmode); end
        for (int i = 2; i < 2 + TO; i++) begin
            @(negedge clk);
            vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL to_early_valid: cycle T+%0d got %b want 0", i, valid); end
        end
        @(negedge clk);
        vectors++; if ({valid, illegal, timeout} !== 3'b101) begin miscompares++; $display("FAIL to_valid: v/i/t=%b want 101", {valid, illegal, timeout}); end
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL to_result: got %h want 0", result); end
        @(negedge clk); unit_res = '0; unit_flags = '0;
        vectors++; if ({valid, busy} !== 2'b00) begin miscompares++; $display("FAIL to_idle: valid/busy=%b want 00", {valid, busy}); end
        vectors++; if (fflags !== 5'b11010) begin miscompares++; $display("FAIL to_fflags: got %b want 11010", fflags); end
    endtask

    task automatic test_abort;
        start = 1'b1; op = fp_op_addsub_c; rm = 3'b000;
        @(negedge clk); start = 1'b0;
        vectors++; if (unit_start !== 4'b0100) begin miscompares++; $display("FAIL ab_start: got %b want 0100", unit_start); end
        @(negedge clk);
        unit_done[0] = 1'b1; unit_res[0] = 32'hdeadbeef; unit_flags[0] = 5'b11111;
        @(negedge clk); unit_done = '0;
        vectors++; if ({valid, busy} !== 2'b01) begin miscompares++; $display("FAIL ab_other_done: valid/busy=%b want 01", {valid, busy}); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        vectors++; if ({valid, busy} !== 2'b00) begin miscompares++; $display("FAIL ab_abort: valid/busy=%b want 00", {valid, busy}); end
        unit_done[2] = 1'b1; unit_res[2] = 32'hcafef00d; unit_flags[2] = 5'b11111;
        @(negedge clk); unit_done = '0;
        vectors++; if ({valid, busy} !== 2'b00 || result !== 32'h0) begin miscompares++;
            $display("FAIL ab_late_done: valid/busy=%b result=%h want 00 0", {valid, busy}, result); end
        @(negedge clk); unit_res = '0; unit_flags = '0;
        vectors++; if (fflags !== 5'b11010) begin miscompares++; $display("FAIL ab_fflags: got %b want 11010", fflags); end
    endtask

    task automatic test_csr_merge;
        fflags_we = 1'b1; fflags_wdata = 5'b00001;
        @(negedge clk); fflags_we = 1'b0;
        vectors++; if (fflags !== 5'b00001) begin miscompares++; $display("FAIL csr_write: got %b want 00001", fflags); end
        start = 1'b1; op = fp_op_direct_c; rm = 3'b011; direct_res = 32'h40000000; direct_flags = 5'b00100;
        @(negedge clk); start = 1'b0; direct_res = '0; direct_flags = '0;
        @(negedge clk);
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL csr_valid: got %b want 1", valid); end
        fflags_we = 1'b1; fflags_wdata = 5'b10000;
        @(negedge clk); fflags_we = 1'b0; fflags_wdata = '0;
        vectors++; if (fflags !== 5'b10100) begin miscompares++; $display("FAIL csr_merge: got %b want 10100", fflags); end
    endtask

    task automatic test_async_reset;
        start = 1'b1; op = fp_op_i2f_c; rm = 3'b011;
        @(negedge clk); start = 1'b0;
        vectors++; if (unit_start !== 4'b0010) begin miscompares++; $display("FAIL rst_start: got %b want 0010", unit_start); end
        @(negedge clk); @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        vectors++; if ({unit_start, rmode, fflags, result} !== '0) begin miscompares++;
            $display("FAIL rst_mid_data: start=%b rmode=%b fflags=%b result=%h want all 0", unit_start, rmode, fflags, result); end
        vectors++; if ({valid, illegal, timeout, busy} !== 4'b0) begin miscompares++;
            $display("FAIL rst_mid_ctrl: valid/illegal/timeout/busy=%b want 0000", {valid, illegal, timeout, busy}); end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        start = 1'b1; op = fp_op_direct_c; rm = 3'b000; direct_res = 32'h12345678; direct_flags = 5'b00001;
        @(negedge clk); start = 1'b0; direct_res = '0; direct_flags = '0;
        @(negedge clk);
        vectors++; if (valid !== 1'b1 || result !== 32'h12345678) begin miscompares++;
            $display("FAIL rst_restart: valid=%b result=%h want 1 12345678", valid, result); end
        @(negedge clk);
        vectors++; if (fflags !== 5'b00001) begin miscompares++; $display("FAIL rst_fflags: got %b want 00001", fflags); end
    endtask

    initial begin
        test_reset();
        test_f2i_dynamic_rm();
        test_illegal(3'd6, 3'b000, 5'b10000);
        test_illegal(fp_op_addsub_c, 3'b101, 5'b10000);
        test_back_to_back();
        test_timeout();
        test_abort();
        test_csr_merge();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
